factory_test_sequencer: RTL and testbench
=========================================

Name: factory_test_sequencer

Overview:
- Sequences the factory-test pin patterns of the chip's user-project pin interface: counter, input loopback, walking-one, and bidirectional loopback.
- Can step through the four modes automatically, or hold the mode selected on dedicated inputs.
- Inserts a blanking window on every mode change so the bidirectional pins never drive during turnaround.
- Sits directly behind the top-level pin wrapper and drives uo_out, uio_out and uio_oe.

Parameters:
- DWELL_CYCLES, 256: RUN cycles per mode in auto mode (≥2).
- BLANK_CYCLES, 2: blanking cycles between modes (≥1).

Ports:
- clk       in   1  system clock
- rst       in   1  synchronous active-high reset
- ena       in   1  design selected; low forces IDLE
- auto_en   in   1  1 = auto-step modes, 0 = manual via mode_sel
- mode_sel  in   2  manual mode request
- ui_in     in   8  dedicated inputs (LOOP_IN source)
- uio_in    in   8  bidir input path
- uo_out    out  8  dedicated outputs
- uio_out   out  8  bidir output path
- uio_oe    out  8  bidir enables (1 = output)
- mode      out  2  current mode
- mode_done out  1  1-cycle pulse when a RUN dwell ends
- rounds    out  8  completed auto rounds (mode 3→0), saturating at 255

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: state=IDLE, mode=0, dwell=0, pat=0, rounds=0, lin=0, mode_done=0.
- Reset outputs: uo_out=0, uio_out=0, uio_oe=0.
- Output timing: all outputs are functions of registered state only; no combinational input→output path.
- States: IDLE, BLANK, RUN.
- IDLE:
  - All outputs 0, uio_oe=0.
  - ena=1 → BLANK; mode loads mode_sel if auto_en=0, else 0.
- BLANK:
  - All outputs 0, uio_oe=0.
  - Counts BLANK_CYCLES cycles, then → RUN with dwell=0 and pat=0.
- RUN, per-cycle behaviour:
  - pat increments by 1 each cycle, mod 256.
  - dwell increments each cycle.
- RUN, auto mode (auto_en=1):
  - Exit condition: the cycle where dwell==DWELL_CYCLES-1.
  - On that cycle: mode_done=1 and next state is BLANK.
  - Mode advances mode+1 (3 wraps to 0) on BLANK entry.
  - On wrap 3→0, rounds increments (saturating).
- RUN, manual mode (auto_en=0):
  - dwell stops at DWELL_CYCLES-1; mode_done is never asserted.
  - If mode_sel≠mode → BLANK, and mode loads mode_sel on BLANK entry.
  - A mode_sel change during BLANK is ignored; it is re-evaluated in RUN.
- Pattern per mode, during RUN:
  - 0 COUNT: uo_out=pat; uio_out=~pat; uio_oe=0xFF.
  - 1 LOOP_IN: uo_out=lin, where lin is ui_in registered once (1-cycle latency); uio_oe=0x00; uio_out=0.
  - 2 WALK: uo_out=8'h01 rotated left by pat[2:0]; uio_out=uo_out; uio_oe=0xFF.
  - 3 BIDIR: uio_oe=0x0F; uio_out={4'h0, pat[3:0]}; uo_out={uio_in[7:4] registered, pat[3:0]}.
- First RUN cycle shows pat=0: COUNT 0x00, WALK 0x01.
- auto_en toggled mid-RUN: takes effect next cycle; dwell is not reset.
- ena falling in any state: IDLE next cycle, with all outputs 0 in that cycle. mode, rounds and pat are held.
- rst wins over every other event; rst mid-RUN returns everything to reset values next cycle.

Decomposition:
- Shared package factory_test_pkg:
  - mode encodings MODE_COUNT=0, MODE_LOOP_IN=1, MODE_WALK=2, MODE_BIDIR=3.
  - state encoding.
  - constants OE_ALL=8'hFF, OE_NONE=8'h00, OE_LOW=8'h0F.
- One natural sub-module, factory_test_pattern_gen:
  - Inputs: mode, pat, lin, uio_in register.
  - Outputs: uo_out/uio_out/uio_oe next values.
  - Owns the pattern table; the sequencer keeps the FSM, dwell/blank counters and rounds.

Test Plan:
- Use DWELL_CYCLES=8, BLANK_CYCLES=2 throughout.
- Reset/IDLE: rst=1 for 2 cycles, ena=0 → uo_out=uio_out=uio_oe=0, mode=0, rounds=0; holds while ena=0.
- Auto sequence: ena=1, auto_en=1 →
  - 2 blank cycles, then uo_out 0x00..0x07 with uio_oe=0xFF.
  - mode_done pulses on the 8th RUN cycle.
  - 2 blank cycles with uio_oe=0, then mode=1.
- Loopback and wrap:
  - In mode 1, drive ui_in=0xA5 → uo_out=0xA5 one cycle later, uio_oe=0.
  - After modes 2 and 3 complete, mode=0 and rounds=1.
- WALK/BIDIR patterns:
  - Mode 2 → uo_out 0x01,0x02,…,0x80 over 8 cycles.
  - Mode 3 with uio_in=0x50 → uio_oe=0x0F, uo_out[7:4]=0x5, uo_out[3:0]=pat[3:0].
- Manual switch: auto_en=0, mode_sel=2 mid-COUNT → next cycle BLANK with all outputs 0 for 2 cycles, then WALK from 0x01; mode_done never asserts.
- Abort: ena=0 mid-RUN in mode 3 → next cycle uio_oe=0, state IDLE. Separately, rst=1 mid-BLANK → mode=0, rounds=0 next cycle.

Source files
------------

// File: rtl/factory_test_pkg.sv
// Shared encodings for the factory-test pin sequencer: modes, FSM states,
// output-enable constants and the bundled pin-drive record.
package factory_test_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_LOOP_IN = 2'd1,
    MODE_WALK    = 2'd2,
    MODE_BIDIR   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam logic [7:0] OE_ALL  = 8'hFF;
  localparam logic [7:0] OE_NONE = 8'h00;
  localparam logic [7:0] OE_LOW  = 8'h0F;

  typedef struct packed {
    logic [7:0] uo;
    logic [7:0] uio;
    logic [7:0] oe;
  } pins_t;

endpackage

// File: rtl/factory_test_pattern_gen.sv
// Pattern table: maps the current mode and registered pattern state onto the
// dedicated and bidirectional pin drives. Everything is parked at zero outside RUN.
module factory_test_pattern_gen
  import factory_test_pkg::*;
(
  input  logic       run_i,
  input  mode_e      mode_i,
  input  logic [7:0] pat_i,
  input  logic [7:0] lin_i,
  input  logic [3:0] uio_hi_i,
  output pins_t      pins_o
);

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    pins_o = '{uo: 8'h00, uio: 8'h00, oe: OE_NONE};
    if (run_i) begin
      unique case (mode_i)
        MODE_COUNT:   pins_o = '{uo: pat_i, uio: ~pat_i, oe: OE_ALL};
        MODE_LOOP_IN: pins_o = '{uo: lin_i, uio: 8'h00, oe: OE_NONE};
        // A single set bit shifted by 0..7 never falls off, so a shift is the rotate.
        MODE_WALK:    pins_o = '{uo: 8'h01 << pat_i[2:0], uio: 8'h01 << pat_i[2:0], oe: OE_ALL};
        MODE_BIDIR:   pins_o = '{uo: {uio_hi_i, pat_i[3:0]}, uio: {4'h0, pat_i[3:0]}, oe: OE_LOW};
        default:      pins_o = '{uo: 8'h00, uio: 8'h00, oe: OE_NONE};
      endcase
    end
  end

endmodule

// File: rtl/factory_test_sequencer.sv
// Factory-test sequencer: IDLE/BLANK/RUN FSM with dwell and blanking counters,
// auto or manual mode stepping, and a round counter. Pin patterns come from the generator.
module factory_test_sequencer
  import factory_test_pkg::*;
#(
  parameter int DWELL_CYCLES = 256,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       auto_en,
  input  logic [1:0] mode_sel,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [1:0] mode,
  output logic       mode_done,
  output logic [7:0] rounds
);

  localparam int DW = $clog2(DWELL_CYCLES);
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [BW-1:0] blank_q, blank_d;
  logic [7:0]    pat_q, pat_d;
  logic [7:0]    rounds_q, rounds_d;
  logic          mode_done_q, mode_done_d;
  logic [7:0]    lin_q;
  logic [3:0]    uio_hi_q;
  logic          unused_uio_lo;
  pins_t         pins;

  assign unused_uio_lo = ^uio_in[3:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_COUNT;
      dwell_q     <= '0;
      blank_q     <= '0;
      pat_q       <= 8'h00;
      rounds_q    <= 8'h00;
      mode_done_q <= 1'b0;
      lin_q       <= 8'h00;
      uio_hi_q    <= 4'h0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      dwell_q     <= dwell_d;
      blank_q     <= blank_d;
      pat_q       <= pat_d;
      rounds_q    <= rounds_d;
      mode_done_q <= mode_done_d;
      lin_q       <= ui_in;
      uio_hi_q    <= uio_in[7:4];
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    dwell_d     = dwell_q;
    blank_d     = blank_q;
    pat_d       = pat_q;
    rounds_d    = rounds_q;
    mode_done_d = 1'b0;
    if (!ena) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          blank_d = '0;
          mode_d  = auto_en ? MODE_COUNT : mode_e'(mode_sel);
        end
        ST_BLANK: begin
          if (blank_q == BLANK_LAST) begin
            state_d = ST_RUN;
            dwell_d = '0;
            pat_d   = 8'h00;
          end else begin
            blank_d = blank_q + 1'b1;
          end
        end
        ST_RUN: begin
          pat_d = pat_q + 8'd1;
          if (auto_en) begin
            // mode_done is raised one cycle early so it is visible during the final dwell cycle.
            if (mode_done_q) begin
              state_d = ST_BLANK;
              blank_d = '0;
              mode_d  = mode_e'(mode_q + 2'd1);
              if (mode_q == MODE_BIDIR && rounds_q != 8'hFF) rounds_d = rounds_q + 8'd1;
            end else begin
              dwell_d     = (dwell_q == DWELL_LAST) ? DWELL_LAST : dwell_q + 1'b1;
              mode_done_d = (dwell_d == DWELL_LAST);
            end
          end else begin
            if (dwell_q != DWELL_LAST) dwell_d = dwell_q + 1'b1;
            if (mode_sel != mode_q) begin
              state_d = ST_BLANK;
              blank_d = '0;
              mode_d  = mode_e'(mode_sel);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  factory_test_pattern_gen u_pattern_gen (
    .run_i    (state_q == ST_RUN),
    .mode_i   (mode_q),
    .pat_i    (pat_q),
    .lin_i    (lin_q),
    .uio_hi_i (uio_hi_q),
    .pins_o   (pins)
  );

  always_comb begin
    uo_out    = pins.uo;
    uio_out   = pins.uio;
    uio_oe    = pins.oe;
    mode      = mode_q;
    mode_done = mode_done_q;
    rounds    = rounds_q;
  end

endmodule

// File: tb/tb_factory_test_sequencer.sv
// Scoreboard bench for factory_test_sequencer: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT pins.
module tb_factory_test_sequencer;

  localparam int DWELL = 8;
  localparam int BLANK = 2;

  typedef struct {
    string      name;
    logic [7:0] uo;
    logic [7:0] uio;
    logic [7:0] oe;
    logic [1:0] mode;
    logic       done;
    logic [7:0] rounds;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, ena, auto_en;
  logic [1:0] mode_sel;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe, rounds;
  logic [1:0] mode;
  logic       mode_done;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  factory_test_sequencer #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .auto_en   (auto_en),
    .mode_sel  (mode_sel),
    .ui_in     (ui_in),
    .uio_in    (uio_in),
    .uo_out    (uo_out),
    .uio_out   (uio_out),
    .uio_oe    (uio_oe),
    .mode      (mode),
    .mode_done (mode_done),
    .rounds    (rounds)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [34:0] got, input logic [34:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got uo/uio/oe/mode/done/rounds=%h expected=%h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, {uo_out, uio_out, uio_oe, mode, mode_done, rounds},
            {e.uo, e.uio, e.oe, e.mode, e.done, e.rounds});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cyc(input string n, input logic [7:0] uo, input logic [7:0] uio,
                            input logic [7:0] oe, input logic [1:0] m, input logic d,
                            input logic [7:0] r);
    exp_t e;
    e = '{n, uo, uio, oe, m, d, r};
    sb.push_back(e);
  endtask

  task automatic blank_cycles(input string n, input logic [1:0] m, input logic [7:0] r);
    repeat (BLANK) begin
      step();
      expect_cyc(n, 8'h00, 8'h00, 8'h00, m, 1'b0, r);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] p;
    rst = 1'b1; ena = 1'b0; auto_en = 1'b0; mode_sel = 2'd0; ui_in = 8'h00; uio_in = 8'h00;
    step(); step();
    expect_cyc("reset", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 8'd0);
    rst = 1'b0;
    repeat (3) begin
      step();
      expect_cyc("idle_hold", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 8'd0);
    end

    // Auto round: COUNT, LOOP_IN, WALK, BIDIR, then wrap to COUNT.
    ena = 1'b1; auto_en = 1'b1; uio_in = 8'h50;
    blank_cycles("blank_count", 2'd0, 8'd0);
    for (int i = 0; i < DWELL; i++) begin
      step();
      p = 8'(i);
      expect_cyc("count", p, ~p, 8'hFF, 2'd0, i == DWELL - 1, 8'd0);
    end
    blank_cycles("blank_loop", 2'd1, 8'd0);
    for (int j = 0; j < DWELL; j++) begin
      step();
      expect_cyc("loop_in", (j == 0) ? 8'h00 : 8'hA5, 8'h00, 8'h00, 2'd1, j == DWELL - 1, 8'd0);
      if (j == 0) ui_in = 8'hA5;
    end
    blank_cycles("blank_walk", 2'd2, 8'd0);
    for (int j = 0; j < DWELL; j++) begin
      step();
      p = 8'h01 << j;
      expect_cyc("walk", p, p, 8'hFF, 2'd2, j == DWELL - 1, 8'd0);
    end
    blank_cycles("blank_bidir", 2'd3, 8'd0);
    for (int j = 0; j < DWELL; j++) begin
      step();
      p = 8'(j);
      expect_cyc("bidir", {4'h5, p[3:0]}, {4'h0, p[3:0]}, 8'h0F, 2'd3, j == DWELL - 1, 8'd0);
    end
    blank_cycles("wrap_blank", 2'd0, 8'd1);

    // Manual switch to WALK in the middle of COUNT.
    for (int i = 0; i < 3; i++) begin
      step();
      p = 8'(i);
      expect_cyc("count_again", p, ~p, 8'hFF, 2'd0, 1'b0, 8'd1);
    end
    auto_en = 1'b0; mode_sel = 2'd2;
    blank_cycles("manual_blank", 2'd2, 8'd1);
    for (int j = 0; j < DWELL + 4; j++) begin
      step();
      p = 8'h01 << (j % 8);
      expect_cyc("manual_walk", p, p, 8'hFF, 2'd2, 1'b0, 8'd1);
    end

    // Manual BIDIR, then abort with ena low.
    mode_sel = 2'd3;
    blank_cycles("manual_blank3", 2'd3, 8'd1);
    for (int j = 0; j < 2; j++) begin
      step();
      p = 8'(j);
      expect_cyc("manual_bidir", {4'h5, p[3:0]}, {4'h0, p[3:0]}, 8'h0F, 2'd3, 1'b0, 8'd1);
    end
    ena = 1'b0;
    step();
    expect_cyc("abort_idle", 8'h00, 8'h00, 8'h00, 2'd3, 1'b0, 8'd1);
    step();
    expect_cyc("abort_hold", 8'h00, 8'h00, 8'h00, 2'd3, 1'b0, 8'd1);

    // Re-enable in manual, then reset in the middle of BLANK.
    ena = 1'b1; mode_sel = 2'd2;
    step();
    expect_cyc("reenable_blank", 8'h00, 8'h00, 8'h00, 2'd2, 1'b0, 8'd1);
    rst = 1'b1;
    step();
    expect_cyc("rst_mid_blank", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 8'd0);
    rst = 1'b0; ena = 1'b0;
    step();
    expect_cyc("post_rst_idle", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 8'd0);

    @(negedge clk);
    #1;
    check("sb_drain", 35'(sb.size()), 35'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
